quadrature_decoder: RTL and testbench
=====================================

QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 4: consecutive cycles a synchronized input level must hold before acceptance; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port enc_a, input, 1: encoder channel A, asynchronous to clk.
REQ-005 SHALL have port enc_b, input, 1: encoder channel B, asynchronous to clk.
REQ-006 SHALL have port enable, input, 1: 1 permits step pulses and error capture.
REQ-007 SHALL have port err_clr, input, 1: synchronous clear of err.
REQ-008 SHALL have port step, output, 1: one-cycle pulse per accepted quarter-cycle transition; drives the counter's clock-enable.
REQ-009 SHALL have port up_down, output, 1: direction of the last step; 0 = up (increment), 1 = down (decrement), matching the downstream up/down counter.
REQ-010 SHALL have port err, output, 1: sticky illegal-transition flag.
REQ-011 SHALL have port quad_state, output, 2: current filtered {a,b} level.

Function
REQ-012 SHALL pass each encoder input through a 2-flop synchronizer before any other logic.
REQ-013 SHALL per channel update the filtered level on the FILTER_CYCLES-th consecutive edge at which the synchronized level differs from it; any edge with equal levels resets that channel's filter count to 0.
REQ-014 SHALL decode filtered {a,b}: 00->10->11->01->00 is up; the reverse order is down; no change produces no action.
REQ-015 SHALL, on an up or down transition with enable=1 in TRACK, assert step for exactly one cycle and register up_down in that same cycle.
REQ-016 SHALL assert step FILTER_CYCLES+2 rising edges after the edge that first captures a new, stable input level; this latency is fixed.
REQ-017 SHALL hold up_down between steps.
REQ-018 SHALL treat a simultaneous change of both filtered bits as illegal: no step, err set if enable=1, quad_state takes the new value.
REQ-019 SHALL give set priority to err when err_clr and an illegal transition occur in the same cycle.
REQ-020 SHALL, with enable=0, keep tracking quad_state but suppress step and err set, so re-enabling causes no spurious step.
REQ-021 SHALL have a 2-state FSM: INIT and TRACK.
REQ-022 SHALL in INIT load the filtered levels directly from the synchronized levels without filtering, generate no step or err, and move to TRACK after FILTER_CYCLES+2 cycles.
REQ-023 SHALL stay in TRACK until reset.

Reset
REQ-024 SHALL on reset clear the synchronizers, filter counts and filtered levels to 0, and set FSM=INIT, step=0, up_down=0, err=0 and quad_state=00.
REQ-025 SHALL let reset asserted mid-filter or mid-pulse abort all in-progress operation immediately, with no step after release until INIT completes.

Structure
REQ-026 SHALL place in a shared package: the FSM state encoding, the direction constants UP=0 and DOWN=1, and the quadrature state constants 00/10/11/01.
REQ-027 SHALL implement synchronizer plus filter as sub-module quad_glitch_filter, instantiated once per channel and parameterized by FILTER_CYCLES.

Verification (FILTER_CYCLES=4)
REQ-028 SHALL cover: reset with enc=00, INIT done, then {a,b} 00->10->11->01->00 with each level held 10 cycles -> 4 step pulses, each 6 edges after its change, up_down=0, quad_state follows.
REQ-029 SHALL cover: reverse sequence 00->01->11->10->00 -> 4 pulses, up_down=1 from the first pulse, err=0.
REQ-030 SHALL cover: a 3-cycle high glitch on enc_a at 00 -> no step, quad_state stays 00; a 4-cycle high pulse -> filtered update then step (up), then a step (down) on return.
REQ-031 SHALL cover: 00->11 with both inputs changed the same cycle -> err=1, no step, quad_state=11; err_clr -> err=0; err_clr coinciding with 11->00 -> err=1.
REQ-032 SHALL cover: enable=0 across 00->10->11, then enable=1 and 11->01 -> exactly one step, up; err=0.
REQ-033 SHALL cover: reset asserted 2 cycles into a filter count while enc=11 -> after release, no step and no err through INIT, quad_state=11; then 11->01 -> one up step.

Source files
------------

// File: rtl/quadrature_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder_pkg
// Purpose  : Shared FSM encoding, direction and quadrature-state constants.
// Revision : 1.0 - initial release
// ============================================================================
package quadrature_decoder_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MV_NONE    = 2'd0,
        MV_UP      = 2'd1,
        MV_DOWN    = 2'd2,
        MV_ILLEGAL = 2'd3
    } move_t;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_10 = 2'b10;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_01 = 2'b01;

    // Position of an {a,b} level along the up sequence 00->10->11->01.
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            QS_00:   pos = 2'd0;
            QS_10:   pos = 2'd1;
            QS_11:   pos = 2'd2;
            QS_01:   pos = 2'd3;
            default: pos = 2'd0;
        endcase
        return pos;
    endfunction

    function automatic move_t quad_move(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] delta;
        move_t      mv;
        delta = quad_pos(cur_ab) - quad_pos(prev_ab);
        case (delta)
            2'd0:    mv = MV_NONE;
            2'd1:    mv = MV_UP;
            2'd3:    mv = MV_DOWN;
            default: mv = MV_ILLEGAL;
        endcase
        return mv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quadrature_decoder_filter.sv
`default_nettype none
// ============================================================================
// Module   : quad_glitch_filter
// Purpose  : 2-flop synchronizer followed by a consecutive-cycle level filter.
// Revision : 1.0 - initial release
// ============================================================================
module quad_glitch_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic load,
    output logic sync_out,
    output logic level
);

    localparam int             CW     = 4;
    localparam logic [CW-1:0] c_last = CW'(FILTER_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            if (load) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else if (r_sync != r_level) begin
                if (r_cnt == c_last) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign sync_out = r_sync;
    assign level    = r_level;

endmodule
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder
// Purpose  : Filtered quadrature decoder producing step / up_down / err.
// Revision : 1.0 - initial release
// ============================================================================
module quadrature_decoder
    import quadrature_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enable,
    input  logic       err_clr,
    output logic       step,
    output logic       up_down,
    output logic       err,
    output logic [1:0] quad_state
);

    localparam int             IW          = 5;
    localparam logic [IW-1:0] c_init_last = IW'(FILTER_CYCLES + 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_init_cnt;

    logic       w_load;
    logic       w_sync_a;
    logic       w_sync_b;
    logic       w_lvl_a;
    logic       w_lvl_b;
    logic [1:0] w_ab;
    logic [1:0] w_sync_ab;
    logic [1:0] r_prev_ab;
    move_t      w_move;
    logic       w_step_next;
    logic       w_err_set;
    logic       r_step;
    logic       r_up_down;
    logic       r_err;

    quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk      (clk),
        .reset    (reset),
        .din      (enc_a),
        .load     (w_load),
        .sync_out (w_sync_a),
        .level    (w_lvl_a)
    );

    quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk      (clk),
        .reset    (reset),
        .din      (enc_b),
        .load     (w_load),
        .sync_out (w_sync_b),
        .level    (w_lvl_b)
    );

    assign w_ab      = {w_lvl_a, w_lvl_b};
    assign w_sync_ab = {w_sync_a, w_sync_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT && r_init_cnt != c_init_last) begin
                r_init_cnt <= r_init_cnt + IW'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step_next  = 1'b0;
        w_err_set    = 1'b0;
        w_move       = quad_move(r_prev_ab, w_ab);
        case (r_state)
            ST_INIT: begin
                w_load = 1'b1;
                if (r_init_cnt == c_init_last) begin
                    w_state_next = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (enable) begin
                    w_step_next = (w_move == MV_UP) || (w_move == MV_DOWN);
                    w_err_set   = (w_move == MV_ILLEGAL);
                end
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // During INIT the history tracks the value being loaded so TRACK starts with no delta.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_ab <= QS_00;
            r_step    <= 1'b0;
            r_up_down <= UP;
            r_err     <= 1'b0;
        end else begin
            r_prev_ab <= w_load ? w_sync_ab : w_ab;
            r_step    <= w_step_next;
            if (w_step_next) begin
                r_up_down <= (w_move == MV_DOWN) ? DOWN : UP;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign step       = r_step;
    assign up_down    = r_up_down;
    assign err        = r_err;
    assign quad_state = w_ab;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quadrature_decoder
// Purpose  : Scoreboard bench for quadrature_decoder with FILTER_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quadrature_decoder;

    // Input set at a negedge is captured on the next posedge; step follows 6 edges later.
    localparam int LAT = 7;

    typedef struct packed {
        logic [31:0] cyc;
        logic        dir;
        logic [1:0]  qs;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       enable;
    logic       err_clr;
    logic       step;
    logic       up_down;
    logic       err;
    logic [1:0] quad_state;

    int          total;
    int          bad;
    logic [31:0] cyc;
    exp_t        sb[$];

    quadrature_decoder #(.FILTER_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .enable     (enable),
        .err_clr    (err_clr),
        .step       (step),
        .up_down    (up_down),
        .err        (err),
        .quad_state (quad_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [1:0] ab, input bit exp_step, input logic dir, input int hold);
        enc_a = ab[1];
        enc_b = ab[0];
        if (exp_step) sb.push_back('{cyc: cyc + LAT, dir: dir, qs: ab});
        repeat (hold) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_step: no step seen, expected at cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (!reset && step) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_step: step=1 at cycle %0d, expected no step", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("step_cycle", cyc, e.cyc);
                check("step_dir", 32'(up_down), 32'(e.dir));
                check("step_qs", 32'(quad_state), 32'(e.qs));
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        enc_a   = 1'b0;
        enc_b   = 1'b0;
        enable  = 1'b1;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_step", 32'(step), 0);
        check("rst_up_down", 32'(up_down), 0);
        check("rst_err", 32'(err), 0);
        check("rst_qs", 32'(quad_state), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Up sequence
        drive(2'b10, 1, 1'b0, 10);
        check("up_qs1", 32'(quad_state), 32'b10);
        drive(2'b11, 1, 1'b0, 10);
        check("up_qs2", 32'(quad_state), 32'b11);
        drive(2'b01, 1, 1'b0, 10);
        check("up_qs3", 32'(quad_state), 32'b01);
        drive(2'b00, 1, 1'b0, 10);
        check("up_qs4", 32'(quad_state), 32'b00);
        check("up_dir_hold", 32'(up_down), 0);

        // Down sequence
        drive(2'b01, 1, 1'b1, 10);
        drive(2'b11, 1, 1'b1, 10);
        drive(2'b10, 1, 1'b1, 10);
        drive(2'b00, 1, 1'b1, 10);
        check("dn_dir_hold", 32'(up_down), 1);
        check("dn_err", 32'(err), 0);
        check("dn_qs", 32'(quad_state), 32'b00);

        // Glitch rejection then a just-long-enough pulse
        drive(2'b10, 0, 1'b0, 3);
        drive(2'b00, 0, 1'b0, 10);
        check("glitch_qs", 32'(quad_state), 32'b00);
        drive(2'b10, 1, 1'b0, 4);
        drive(2'b00, 1, 1'b1, 12);
        check("pulse_qs", 32'(quad_state), 32'b00);

        // Illegal double change, clear, then clear racing a new illegal change
        drive(2'b11, 0, 1'b0, 10);
        check("ill_err", 32'(err), 1);
        check("ill_qs", 32'(quad_state), 32'b11);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_err", 32'(err), 0);
        drive(2'b00, 0, 1'b0, LAT - 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_race_err", 32'(err), 1);
        repeat (4) @(negedge clk);
        check("clr_race_qs", 32'(quad_state), 32'b00);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Disabled tracking, then re-enable
        enable = 1'b0;
        drive(2'b10, 0, 1'b0, 10);
        drive(2'b11, 0, 1'b0, 10);
        check("dis_qs", 32'(quad_state), 32'b11);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        drive(2'b01, 1, 1'b0, 10);
        check("en_err", 32'(err), 0);
        check("en_qs", 32'(quad_state), 32'b01);

        // Reset two cycles into a filter count
        drive(2'b11, 0, 1'b0, 4);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_qs", 32'(quad_state), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_step", 32'(step), 0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_qs", 32'(quad_state), 32'b11);
        check("post_rst_err", 32'(err), 0);
        drive(2'b01, 1, 1'b0, 10);
        check("post_rst_dir", 32'(up_down), 0);

        repeat (5) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
